// File: rtl/traffic_sequencer_pkg.sv
// Shared types and helpers for the traffic phase sequencer.
// Lamp and phase encodings are externally visible and must stay fixed.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        WALK      = 3'd6
    } phase_t;

    typedef struct packed {
        light_t ns;
        light_t ew;
        logic   walk;
    } lamps_t;

    // A programmed duration of zero still holds the phase for one tick.
    function automatic int unsigned min_one(input int unsigned x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic lamps_t decode_lamps(input phase_t p);
        lamps_t l;
        l = '{ns: RED, ew: RED, walk: 1'b0};
        case (p)
            NS_GREEN:  l.ns = GREEN;
            NS_YELLOW: l.ns = YELLOW;
            EW_GREEN:  l.ew = GREEN;
            EW_YELLOW: l.ew = YELLOW;
            WALK:      l.walk = 1'b1;
            default:   l = '{ns: RED, ew: RED, walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_sequencer_if.sv
// Timer handshake, pedestrian button and lamp outputs of the sequencer.
// timer_done is a one-cycle pulse honoured only while timer_enable is high.
interface traffic_sequencer_if;
    import traffic_pkg::*;

    logic   timer_done;
    logic   ped_request;
    logic   timer_enable;
    light_t ns_light;
    light_t ew_light;
    logic   walk;
    logic   ped_ack;
    phase_t phase;

    modport master (
        input  timer_done,
        input  ped_request,
        output timer_enable,
        output ns_light,
        output ew_light,
        output walk,
        output ped_ack,
        output phase
    );

    modport slave (
        output timer_done,
        output ped_request,
        input  timer_enable,
        input  ns_light,
        input  ew_light,
        input  walk,
        input  ped_ack,
        input  phase
    );

endinterface

// File: rtl/traffic_sequencer_tick_counter.sv
// Counts qualified timer ticks and flags the tick that completes a phase.
// Self-clears on expiry so the count never exceeds limit-1.
module tick_counter #(
    parameter int TICK_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              tick,
    input  logic [TICK_W-1:0] limit,
    output logic              expire
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    assign expire = tick && (cnt_q == (limit - TICK_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expire) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_sequencer.sv
// Four-way intersection phase controller driven by an upstream period timer,
// with a latched pedestrian request served by an all-red WALK phase.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 4,
    parameter int YELLOW_TICKS = 1,
    parameter int RED_TICKS    = 1,
    parameter int WALK_TICKS   = 3,
    parameter int TICK_W       = 8
) (
    input logic               clock,
    input logic               reset,
    traffic_sequencer_if.master bus
);

    localparam logic [TICK_W-1:0] GreenLim  = TICK_W'(min_one(GREEN_TICKS));
    localparam logic [TICK_W-1:0] YellowLim = TICK_W'(min_one(YELLOW_TICKS));
    localparam logic [TICK_W-1:0] RedLim    = TICK_W'(min_one(RED_TICKS));
    localparam logic [TICK_W-1:0] WalkLim   = TICK_W'(min_one(WALK_TICKS));

    phase_t            state_q, state_d;
    logic              en_q, en_d;
    logic              pend_q, pend_d;
    logic              ack_q, ack_d;
    lamps_t            lamps_q, lamps_d;
    logic              tick;
    logic              expire;
    logic [TICK_W-1:0] limit;

    // Pulses arriving during the realignment cycle must not count.
    assign tick = bus.timer_done && en_q;

    always_comb begin
        case (state_q)
            NS_GREEN, EW_GREEN:   limit = GreenLim;
            NS_YELLOW, EW_YELLOW: limit = YellowLim;
            WALK:                 limit = WalkLim;
            default:              limit = RedLim;
        endcase
    end

    tick_counter #(
        .TICK_W (TICK_W)
    ) u_tick_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (!en_q),
        .tick   (tick),
        .limit  (limit),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        en_d    = 1'b1;
        ack_d   = 1'b0;
        pend_d  = pend_q || (bus.ped_request && (state_q != WALK));
        if (expire) begin
            en_d = 1'b0;
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = ALL_RED_A;
                ALL_RED_A: state_d = EW_GREEN;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = ALL_RED_B;
                ALL_RED_B: begin
                    if (pend_d) begin
                        state_d = WALK;
                        pend_d  = 1'b0;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = NS_GREEN;
                    end
                end
                default:   state_d = NS_GREEN;
            endcase
        end
        // Decoding the next state keeps the registered lamps aligned with state_q.
        lamps_d = decode_lamps(state_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ALL_RED_B;
            en_q    <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            lamps_q <= '{ns: RED, ew: RED, walk: 1'b0};
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            lamps_q <= lamps_d;
        end
    end

    assign bus.timer_enable = en_q;
    assign bus.ns_light     = lamps_q.ns;
    assign bus.ew_light     = lamps_q.ew;
    assign bus.walk         = lamps_q.walk;
    assign bus.ped_ack      = ack_q;
    assign bus.phase        = state_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer: emulated 10-cycle timer, directed and random
// pedestrian/reset stimulus, cycle-by-cycle comparison against a phase-length model.
module tb_traffic_sequencer;
  import traffic_pkg::*;

  localparam int TP = 10;

  logic clock;
  logic reset;
  logic force_done;
  int   n_checks;
  int   n_fail;

  // reference model state: phase index, cycles since entry, pending request, ack
  int   m_ph;
  int   m_age;
  bit   m_pend;
  bit   m_ack;

  traffic_sequencer_if bus ();

  traffic_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int phase_cycles(input int ph);
    int ticks;
    case (ph)
      0, 3:    ticks = 4;
      1, 4:    ticks = 1;
      6:       ticks = 3;
      default: ticks = 1;
    endcase
    if (ticks == 0) ticks = 1;
    return ticks * TP + 1;
  endfunction

  // timer emulation: done pulses on the 10th consecutive enabled cycle
  initial begin : timer_model
    int tcnt;
    tcnt = 0;
    bus.timer_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.timer_enable !== 1'b1) begin
        tcnt = 0;
        bus.timer_done = force_done;
      end else begin
        tcnt++;
        bus.timer_done = (tcnt == TP);
        if (tcnt == TP) tcnt = 0;
      end
    end
  end

  // scoreboard: advance model at each edge, compare DUT 2 time units later
  initial begin : monitor
    bit r;
    bit p;
    int exp_ns;
    int exp_ew;
    forever begin
      @(posedge clock);
      r = reset;
      p = bus.ped_request;
      m_ack = 1'b0;
      if (r) begin
        m_ph = 5; m_age = 0; m_pend = 1'b0;
      end else begin
        if (p && m_ph != 6) m_pend = 1'b1;
        m_age++;
        if (m_age == phase_cycles(m_ph)) begin
          m_age = 0;
          if (m_ph == 5) begin
            if (m_pend) begin
              m_ph = 6; m_pend = 1'b0; m_ack = 1'b1;
            end else begin
              m_ph = 0;
            end
          end else if (m_ph == 6) begin
            m_ph = 0;
          end else begin
            m_ph = m_ph + 1;
          end
        end
      end
      #2;
      exp_ns = (m_ph == 0) ? 2 : (m_ph == 1) ? 1 : 0;
      exp_ew = (m_ph == 3) ? 2 : (m_ph == 4) ? 1 : 0;
      check_eq("phase", int'(bus.phase), m_ph);
      check_eq("ns_light", int'(bus.ns_light), exp_ns);
      check_eq("ew_light", int'(bus.ew_light), exp_ew);
      check_eq("walk", int'(bus.walk), int'(m_ph == 6));
      check_eq("ped_ack", int'(bus.ped_ack), int'(m_ack));
      check_eq("timer_enable", int'(bus.timer_enable), int'(m_age != 0));
      check_eq("lamp_invariant", int'(bus.ns_light != RED && bus.ew_light != RED), 0);
    end
  end

  // driver tasks
  task automatic pulse_ped();
    bus.ped_request = 1'b1;
    @(negedge clock);
    bus.ped_request = 1'b0;
  endtask

  task automatic wait_model(input int target, input int budget);
    int n;
    n = 0;
    while (m_ph != target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (m_ph != target) check_eq("wait_timeout", m_ph, target);
  endtask

  initial begin : stimulus
    n_checks = 0;
    n_fail = 0;
    m_ph = 5; m_age = 0; m_pend = 1'b0; m_ack = 1'b0;
    reset = 1'b1;
    force_done = 1'b0;
    bus.ped_request = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // free run, two full cycles without requests
    wait_model(0, 40);
    repeat (260) @(negedge clock);

    // request during EW_GREEN, then a dropped request during WALK
    wait_model(3, 200);
    repeat (5) @(negedge clock);
    pulse_ped();
    wait_model(6, 200);
    repeat (3) @(negedge clock);
    pulse_ped();
    wait_model(0, 100);
    repeat (260) @(negedge clock);

    // done asserted in every realignment cycle
    force_done = 1'b1;
    repeat (300) @(negedge clock);
    force_done = 1'b0;

    // reset mid-EW_GREEN with a request pending
    wait_model(0, 300);
    pulse_ped();
    wait_model(3, 300);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (150) @(negedge clock);

    // random requests and occasional resets
    repeat (2000) begin
      bus.ped_request = ($urandom_range(0, 99) < 4);
      reset = ($urandom_range(0, 499) == 0);
      force_done = ($urandom_range(0, 9) == 0);
      @(negedge clock);
    end
    bus.ped_request = 1'b0;
    reset = 1'b0;
    force_done = 1'b0;
    repeat (20) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_sequencer.md
# traffic_sequencer

Phase controller that sits directly upstream of `timer`: drives its `enable` input and consumes its `done_signal` pulses as base ticks. It steps a four-way intersection through a fixed green/yellow/all-red cycle, counting a parameterised number of timer ticks per phase. It also serves a latched pedestrian request with an all-red WALK phase.

## Interface
Parameters:
- `GREEN_TICKS`, 4: timer ticks per green phase
- `YELLOW_TICKS`, 1: ticks per yellow phase
- `RED_TICKS`, 1: ticks per all-red clearance phase
- `WALK_TICKS`, 3: ticks per WALK phase
- `TICK_W`, 8: width of the tick counter; every `*_TICKS` value is < 2^TICK_W

Ports:
- `clock`  in  1: single clock, rising edge
- `reset`  in  1: synchronous, active-high
- `timer_done`  in  1: from `timer.done_signal`; one-cycle pulse per elapsed timer period
- `ped_request`  in  1: pedestrian button, level or pulse, already synchronous to `clock`
- `timer_enable`  out  1: to `timer.enable`; low clears the timer, high lets it count
- `ns_light`  out  2: north-south lamp (`light_t`)
- `ew_light`  out  2: east-west lamp (`light_t`)
- `walk`  out  1: pedestrian WALK lamp
- `ped_ack`  out  1: one-cycle pulse on entry to WALK
- `phase`  out  3: current state (`phase_t`), for debug

## Operation
- Timer contract: `enable` low clears the timer count. `done_signal` pulses for one cycle every period of continuous `enable` high.
- States (`phase_t`): NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B, WALK.
- Cycle: NS_GREEN → NS_YELLOW → ALL_RED_A → EW_GREEN → EW_YELLOW → ALL_RED_B → (WALK if `ped_pending`, else NS_GREEN). WALK → NS_GREEN.
- Durations: greens `GREEN_TICKS`, yellows `YELLOW_TICKS`, all-reds `RED_TICKS`, WALK `WALK_TICKS`. A programmed value of 0 is treated as 1.
- Tick counter: `tick_cnt` increments on each `timer_done` seen while `timer_enable` is high.
  - When `timer_done` is high and `tick_cnt == duration-1`, the state advances and `tick_cnt` clears.
  - No wrap-around: `tick_cnt` never exceeds duration-1.
- Timer realignment: `timer_enable` is low for exactly the one cycle after each state change, then high. Every phase therefore starts on a full timer period.
- `timer_done` arriving while `timer_enable` is low is ignored.
- Pedestrian latch: `ped_pending` is set by `ped_request` in any state except WALK, and cleared on entry to WALK.
  - `ped_request` during WALK is dropped.
  - `ped_request` in the same cycle as the ALL_RED_B→decision edge is counted and served this cycle.
- Lamp decode (Moore, from state register; values per `light_t`):
  - NS_GREEN: ns=GREEN, ew=RED.
  - NS_YELLOW: ns=YELLOW, ew=RED.
  - EW_GREEN: ns=RED, ew=GREEN.
  - EW_YELLOW: ns=RED, ew=YELLOW.
  - ALL_RED_A, ALL_RED_B, WALK: both RED.
  - `walk`=1 only in WALK.
- Safety invariant: `ns_light` and `ew_light` are never both non-RED.

## Timing
- Reset (synchronous, any state, mid-phase included) puts the block in ALL_RED_B, with `tick_cnt`=0, `ped_pending`=0 and `timer_enable`=0.
  - Reset outputs: both lamps RED, `walk`=0, `ped_acka`=0, `phase`=ALL_RED_B.
  - First edge after `reset` falls: `timer_enable`=1.
- Transition latency: state, lamps and `phase` change on the edge following the final qualifying `timer_done` pulse (1 cycle).
- `ped_ack` is high in the first cycle of WALK only.
- Phase length in cycles = duration × timer period + 1 (the realignment cycle).

## Structure
- Package `traffic_pkg`:
  - `light_t` enum (RED=2'b00, YELLOW=2'b01, GREEN=2'b10).
  - `phase_t` enum, 3 bits, encodings in listed order starting at 0.
- One sub-module, `tick_counter`:
  - Inputs: `clock`, `reset`, `clear`, `tick`, `limit`.
  - Output: `expire`, high when `tick` && count==limit-1.
  - The sequencer instantiates it once and muxes `limit` by state.

## Test plan
Bench drives `timer_done` as a one-cycle pulse 10 cycles after `timer_enable` rises, repeating every 10 cycles; default parameters.
- Reset held 3 cycles, then released → both RED, `phase`=ALL_RED_B. `timer_enable` goes 0→1 one cycle after release. NS_GREEN entered after 1 tick (11 cycles).
- Free run, no request → sequence NS_G(41)/NS_Y(11)/AR_A(11)/EW_G(41)/EW_Y(11)/AR_B(11) cycles, never WALK. Invariant checked every cycle.
- `ped_request` one-cycle pulse during EW_GREEN → WALK after ALL_RED_B, `walk`=1 for 31 cycles, `ped_ack` single pulse. The next cycle has no WALK.
- `ped_request` pulse during WALK only → dropped; following ALL_RED_B goes straight to NS_GREEN.
- `timer_done` forced high during a realignment cycle → ignored; phase length unchanged.
- `reset` asserted mid-EW_GREEN with `ped_pending`=1 → next cycle ALL_RED_B, `tick_cnt`=0, request cleared, no WALK on the following cycle.
